// File: rtl/misc_v_pkg.sv
// misc_v_pkg: shared widths, fetch FSM states and prefetch entry type for the MISC-V core.
// Rev 1.0
`default_nettype none

package misc_v_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;
  localparam int PC_STEP = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_unit_fifo.sv
// fetch_fifo: DEPTH-entry synchronous prefetch queue of {pc,instr} with push/pop/flush.
// Rev 1.0
`default_nettype none

module fetch_fifo
  import misc_v_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  // Flush wins over both ends so a redirect leaves the queue empty.
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && !empty;
  assign empty   = (count == '0);
  assign head    = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(do_push && !do_pop && (count == CW'(DEPTH))));

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and in-order imem requester feeding decode via a prefetch queue.
// Rev 1.0 -- IFETCH_STALL_CNT_EN adds the stall_cnt output.
`default_nettype none

module instr_fetch_unit
  import misc_v_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [15:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [15:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        halt_req,
`ifdef IFETCH_STALL_CNT_EN
  output logic [31:0] stall_cnt,
`endif
  output logic        halted
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_L = (CW+1)'(DEPTH);

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc, rsp_pc, redirect_tgt;
  logic [CW-1:0]     outstanding, out_nxt, drop, count;
  logic              credit_ok, req_fire, drop_rsp, push, pop, empty;
  fetch_entry_t      head, push_data;
  logic              unused_bit0;

  assign unused_bit0  = redirect_pc[0];
  assign redirect_tgt = {redirect_pc[15:1], 1'b0};

  // Outstanding requests plus queued words never exceed DEPTH, so every response has a slot.
  assign credit_ok      = ({1'b0, outstanding} + {1'b0, count}) < DEPTH_L;
  assign imem_req_valid = (state == FETCH) && !halt_req && credit_ok;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign drop_rsp  = imem_rsp_valid && (redirect_valid || (drop != '0));
  assign push      = imem_rsp_valid && !drop_rsp;
  assign push_data = '{pc: rsp_pc, instr: imem_rsp_data};
  assign out_nxt   = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

  assign if_valid = !empty;
  assign if_instr = empty ? '0 : head.instr;
  assign if_pc    = empty ? '0 : head.pc;
  assign pop      = if_valid && if_ready;
  assign halted   = (state == HALT) && (outstanding == '0);

  fetch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (count),
    .empty     (empty)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   if (halt_req)  state_nxt = HALT;
      HALT:    if (!halt_req) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= out_nxt;
      if (redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old path.
        fetch_pc <= redirect_tgt;
        rsp_pc   <= redirect_tgt;
        drop     <= out_nxt;
      end else begin
        if (req_fire)                          fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
        if (push)                              rsp_pc   <= rsp_pc + ADDR_W'(PC_STEP);
        if (imem_rsp_valid && (drop != '0))    drop     <= drop - 1'b1;
      end
    end
  end

`ifdef IFETCH_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((state == FETCH) && if_ready && !if_valid && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed + random checks of instr_fetch_unit against an epoch/queue model.
// Rev 1.0
`default_nettype none

module tb_instr_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [15:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [15:0] imem_rsp_data;
  logic        if_valid, if_ready;
  logic [15:0] if_instr, if_pc;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt_req, halted;
`ifdef IFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(16'h0000), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
`ifdef IFETCH_STALL_CNT_EN
    .stall_cnt      (stall_cnt),
`endif
    .halted         (halted)
  );

  typedef struct { logic [15:0] addr; int epoch; longint due; } req_t;
  typedef struct { logic [15:0] pc; logic [15:0] instr; } word_t;

  req_t        memq[$];     // accepted requests not yet answered by memory
  word_t       sq[$];       // words decode should see, in order
  logic [15:0] acc_log[$];  // accepted request addresses
  int          checks = 0, errors = 0;
  int          st;          // 0 idle, 1 fetching, 2 halted-mode
  int          epoch;
  longint      cyc, last_due;
  logic [15:0] exp_req;
  logic [31:0] stall_m;
  int          pops;
  bit          watch_first;
  logic [15:0] first_pc;

  bit          k_if_ready, k_req_ready, k_halt, k_redirect;
  logic [15:0] k_rpc;
  int          k_lat_min, k_lat_max;

  function automatic logic [15:0] memf(logic [15:0] a);
    logic [15:0] p;
    p = a * 16'h9E37;
    return p ^ 16'h5A5A;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered and left at a falling edge; the model advances as if across the rising edge.
  task automatic cycle();
    req_t   r;
    bit     rsp_now, red, exp_rv;
    int     out, lat;
    longint due;
    if_ready       = k_if_ready;
    imem_req_ready = k_req_ready;
    halt_req       = k_halt;
    redirect_valid = k_redirect;
    redirect_pc    = k_rpc;
    k_redirect     = 1'b0;
    rsp_now        = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      r = memq.pop_front();
      rsp_now = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(r.addr);
    end
    #1;
    out    = memq.size() + int'(rsp_now);
    exp_rv = (st == 1) && !halt_req && ((out + sq.size()) < DEPTH);
    check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) check("req_addr", 32'(imem_req_addr), 32'(exp_req));
    check("if_valid", 32'(if_valid), 32'(sq.size() > 0));
    if (sq.size() > 0) begin
      check("if_pc", 32'(if_pc), 32'(sq[0].pc));
      check("if_instr", 32'(if_instr), 32'(sq[0].instr));
    end
    check("halted", 32'(halted), 32'((st == 2) && (out == 0)));
`ifdef IFETCH_STALL_CNT_EN
    check("stall_cnt", stall_cnt, stall_m);
    if (st == 1 && if_ready && sq.size() == 0 && stall_m != 32'hFFFF_FFFF) stall_m++;
`endif
    red = redirect_valid;
    if (imem_req_valid && imem_req_ready) begin
      lat = $urandom_range(k_lat_max, k_lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      memq.push_back('{addr: imem_req_addr, epoch: epoch, due: due});
      acc_log.push_back(imem_req_addr);
      exp_req = exp_req + 16'd2;
    end
    if (!red && if_ready && sq.size() > 0) begin
      if (watch_first) begin first_pc = sq[0].pc; watch_first = 1'b0; end
      void'(sq.pop_front());
      pops++;
    end
    if (rsp_now && !red && r.epoch == epoch) sq.push_back('{pc: r.addr, instr: memf(r.addr)});
    if (red) begin
      sq.delete();
      epoch++;
      exp_req = {redirect_pc[15:1], 1'b0};
    end
    if (st == 0) st = 1;
    else         st = halt_req ? 2 : 1;
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", 32'(imem_req_addr), 32'h0000);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_instr", 32'(if_instr), 32'd0);
    check("rst_if_pc", 32'(if_pc), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
`ifdef IFETCH_STALL_CNT_EN
    check("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    memq.delete(); sq.delete();
    st = 0; epoch = 0; last_due = 0; exp_req = 16'h0000; stall_m = 0;
    k_halt = 1'b0; k_redirect = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] resume_addr;
    int          n0;
    rst_n = 1'b1; cyc = 0; pops = 0; watch_first = 1'b0; first_pc = '0;
    if_ready = 0; imem_req_ready = 0; halt_req = 0; redirect_valid = 0; redirect_pc = '0;
    imem_rsp_valid = 0; imem_rsp_data = '0;
    k_if_ready = 1; k_req_ready = 1; k_halt = 0; k_redirect = 0; k_rpc = '0;
    k_lat_min = 1; k_lat_max = 1;
    @(negedge clk);
    do_reset();

    // Latency-1 streaming from reset
    repeat (30) cycle();
    check("p1_stream", 32'(pops >= 10), 32'd1);
    check("p1_first_addrs", {acc_log[0], acc_log[1]}, 32'h0000_0002);

    // Decode stalls: queue fills to DEPTH, then drains exactly DEPTH words
    k_if_ready = 0;
    repeat (12) cycle();
    check("p2_req_blocked", 32'(imem_req_valid), 32'd0);
    k_req_ready = 0; k_if_ready = 1; n0 = pops;
    repeat (6) cycle();
    check("p2_drain", 32'(pops - n0), 32'(DEPTH));

    // Two outstanding, redirect to an odd target
    k_req_ready = 1; k_lat_min = 3; k_lat_max = 3;
    for (int i = 0; i < 10 && memq.size() != 2; i++) cycle();
    check("p3_two_out", 32'(memq.size()), 32'd2);
    k_redirect = 1; k_rpc = 16'h0101; watch_first = 1'b1;
    cycle();
    acc_log.delete();
    repeat (20) cycle();
    check("p3_next_addr", 32'(acc_log[0]), 32'h0100);
    check("p3_first_pc", 32'(first_pc), 32'h0100);

    // Halt with one request outstanding
    k_req_ready = 0;
    repeat (8) cycle();
    k_req_ready = 1;
    cycle();
    k_req_ready = 0; k_halt = 1;
    resume_addr = acc_log[acc_log.size()-1] + 16'd2;
    cycle();
    check("p4_halted_early", 32'(halted), 32'd0);
    repeat (6) cycle();
    check("p4_halted", 32'(halted), 32'd1);
    k_halt = 0; k_req_ready = 1;
    cycle();
    check("p4_resume_addr", 32'(imem_req_addr), 32'(resume_addr));
    repeat (10) cycle();

    // Wrap at the top of the address space
    k_lat_min = 1; k_lat_max = 2;
    k_redirect = 1; k_rpc = 16'hFFFE;
    cycle();
    acc_log.delete();
    repeat (10) cycle();
    check("p5_wrap", {acc_log[0], acc_log[1]}, 32'hFFFE_0000);

    // Random traffic with an asynchronous reset in the middle
    k_lat_min = 1; k_lat_max = 4;
    for (int i = 0; i < 600; i++) begin
      k_if_ready  = ($urandom_range(3, 0) != 0);
      k_req_ready = ($urandom_range(9, 0) < 7);
      if ($urandom_range(29, 0) == 0) begin
        k_redirect = 1; k_rpc = 16'($urandom());
      end
      if ($urandom_range(39, 0) == 0) k_halt = !k_halt;
      if (i == 300) do_reset();
      cycle();
    end

    // Latency-3 from reset with decode always ready
    k_halt = 0; k_if_ready = 1; k_req_ready = 1; k_lat_min = 3; k_lat_max = 3;
    do_reset();
    repeat (30) cycle();
`ifdef IFETCH_STALL_CNT_EN
    check("p6_stall_nonzero", 32'(stall_cnt != 0), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
